// File: rtl/led_event_scheduler.sv
// Event scheduler between the click detector and the LED toggle block.
// Queues click events per channel and issues them one at a time, round-robin,
// onto a one-hot toggle strobe, with an idle gap after every toggle so each
// LED change stays visible.
module led_event_scheduler #(
  parameter int CNT_W      = 2,
  parameter int GAP_CYCLES = 25000000,
  parameter int GAP_W      = 25
) (
  input  logic       CLOCK,
  input  logic       RST_n,
  input  logic [2:0] Event_In,
  input  logic       Enable,
  input  logic       Clear,
  output logic [2:0] Pin_Out,
  output logic       Busy,
  output logic [2:0] Drop_Flag
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt [3];
  logic [2:0]       pending;
  logic [2:0]       issue;
  logic [2:0]       grant;
  logic [1:0]       last;
  logic [1:0]       last_next;
  logic [1:0]       idx;
  logic [GAP_W-1:0] gap_cnt;

  // Per-channel "has work" flags and the channel being decremented this cycle.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      pending[i] = (cnt[i] != '0);
    end
    issue = (state == ISSUE) ? Pin_Out : 3'b000;
  end

  // Round-robin pick: first pending channel after the last one granted.
  always_comb begin
    // NOTE: every variable gets a default before any conditional write, so no latch is inferred.
    grant     = 3'b000;
    last_next = last;
    idx       = 2'd0;
    for (int k = 1; k <= 3; k++) begin
      idx = 2'((int'(last) + k) % 3);
      if (grant == 3'b000 && pending[idx]) begin
        grant[idx] = 1'b1;
        last_next  = idx;
      end
    end
  end

  // Next-state logic for the issue/gap sequencer.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (Enable && (pending != 3'b000)) state_next = ISSUE;
      ISSUE:   state_next = GAP;
      GAP:     if (gap_cnt == GAP_LAST) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Sequencer state, gap timer, RR pointer and registered strobe outputs.
  always_ff @(posedge CLOCK or negedge RST_n) begin
    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    if (!RST_n) begin
      state   <= IDLE;
      gap_cnt <= '0;
      last    <= 2'd2;
      Pin_Out <= 3'b000;
      Busy    <= 1'b0;
    end else if (Clear) begin
      state   <= IDLE;
      gap_cnt <= '0;
      Pin_Out <= 3'b000;
      Busy    <= 1'b0;
    end else begin
      state   <= state_next;
      Busy    <= (state_next != IDLE);
      gap_cnt <= (state == GAP && state_next == GAP) ? gap_cnt + 1'b1 : '0;
      if (state == IDLE && state_next == ISSUE) begin
        Pin_Out <= grant;
        last    <= last_next;
      end else begin
        Pin_Out <= 3'b000;
      end
    end
  end

  // Pending counters: count events in, grants out, flag events lost to saturation.
  always_ff @(posedge CLOCK or negedge RST_n) begin
    if (!RST_n) begin
      for (int i = 0; i < 3; i++) cnt[i] <= '0;
      Drop_Flag <= 3'b000;
    end else if (Clear) begin
      for (int i = 0; i < 3; i++) cnt[i] <= '0;
      Drop_Flag <= 3'b000;
    end else begin
      Drop_Flag <= 3'b000;
      for (int i = 0; i < 3; i++) begin
        unique case ({Event_In[i], issue[i]})
          2'b10: begin
            if (cnt[i] == CNT_MAX) Drop_Flag[i] <= 1'b1;
            else                   cnt[i] <= cnt[i] + 1'b1;
          end
          2'b01:   cnt[i] <= cnt[i] - 1'b1;
          default: cnt[i] <= cnt[i];
        endcase
      end
    end
  end

endmodule

// File: tb/tb_led_event_scheduler.sv
// Directed bench for led_event_scheduler with a short gap (GAP_CYCLES=4).
// Each task drives one scenario cycle by cycle and compares outputs at the
// falling edge against hand-computed expectations.
module tb_led_event_scheduler;

  logic       CLOCK;
  logic       RST_n;
  logic [2:0] Event_In;
  logic       Enable;
  logic       Clear;
  logic [2:0] Pin_Out;
  logic       Busy;
  logic [2:0] Drop_Flag;

  int tests_run    = 0;
  int tests_failed = 0;

  led_event_scheduler #(
    .CNT_W      (2),
    .GAP_CYCLES (4),
    .GAP_W      (4)
  ) dut (
    .CLOCK     (CLOCK),
    .RST_n     (RST_n),
    .Event_In  (Event_In),
    .Enable    (Enable),
    .Clear     (Clear),
    .Pin_Out   (Pin_Out),
    .Busy      (Busy),
    .Drop_Flag (Drop_Flag)
  );

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  // Reset, then leave the bench just after a rising edge (start of cycle 0).
  task automatic do_reset();
    RST_n    = 1'b0;
    Event_In = 3'b000;
    Enable   = 1'b1;
    Clear    = 1'b0;
    repeat (2) @(posedge CLOCK);
    @(negedge CLOCK);
    RST_n = 1'b1;
    @(posedge CLOCK);
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge CLOCK);
    tests_run++;
    if (Pin_Out !== 3'b000) begin
      tests_failed++;
      $display("FAIL reset_pin got=%b exp=000", Pin_Out);
    end
    tests_run++;
    if (Busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_busy got=%b exp=0", Busy);
    end
    tests_run++;
    if (Drop_Flag !== 3'b000) begin
      tests_failed++;
      $display("FAIL reset_drop got=%b exp=000", Drop_Flag);
    end
    @(posedge CLOCK);
    #1;
  endtask

  // One event on channel 0: pulse at c=2, busy c=2..6.
  task automatic test_single();
    logic [2:0] exp_pin;
    logic       exp_busy;
    do_reset();
    for (int c = 0; c < 10; c++) begin
      Event_In = (c == 0) ? 3'b001 : 3'b000;
      @(negedge CLOCK);
      exp_pin  = (c == 2) ? 3'b001 : 3'b000;
      exp_busy = (c >= 2 && c <= 6);
      tests_run++;
      if (Pin_Out !== exp_pin) begin
        tests_failed++;
        $display("FAIL single_pin c=%0d got=%b exp=%b", c, Pin_Out, exp_pin);
      end
      tests_run++;
      if (Busy !== exp_busy) begin
        tests_failed++;
        $display("FAIL single_busy c=%0d got=%b exp=%b", c, Busy, exp_busy);
      end
      @(posedge CLOCK);
      #1;
    end
  endtask

  // All three channels at once: 001 @2, 010 @8, 100 @14, then quiet.
  task automatic test_burst();
    logic [2:0] exp_pin;
    logic       exp_busy;
    do_reset();
    for (int c = 0; c < 26; c++) begin
      Event_In = (c == 0) ? 3'b111 : 3'b000;
      @(negedge CLOCK);
      case (c)
        2:       exp_pin = 3'b001;
        8:       exp_pin = 3'b010;
        14:      exp_pin = 3'b100;
        default: exp_pin = 3'b000;
      endcase
      exp_busy = (c >= 2 && c <= 18) && !(c == 7 || c == 13);
      tests_run++;
      if (Pin_Out !== exp_pin) begin
        tests_failed++;
        $display("FAIL burst_pin c=%0d got=%b exp=%b", c, Pin_Out, exp_pin);
      end
      tests_run++;
      if (Busy !== exp_busy) begin
        tests_failed++;
        $display("FAIL burst_busy c=%0d got=%b exp=%b", c, Busy, exp_busy);
      end
      @(posedge CLOCK);
      #1;
    end
  endtask

  // Five events on channel 1 while held: two drops, then exactly three issues.
  task automatic test_saturation();
    logic [2:0] exp_pin;
    logic [2:0] exp_drop;
    do_reset();
    Enable = 1'b0;
    for (int c = 0; c < 31; c++) begin
      Event_In = (c <= 4) ? 3'b010 : 3'b000;
      Enable   = (c >= 8);
      @(negedge CLOCK);
      exp_drop = (c == 4 || c == 5) ? 3'b010 : 3'b000;
      exp_pin  = (c == 9 || c == 15 || c == 21) ? 3'b010 : 3'b000;
      tests_run++;
      if (Drop_Flag !== exp_drop) begin
        tests_failed++;
        $display("FAIL sat_drop c=%0d got=%b exp=%b", c, Drop_Flag, exp_drop);
      end
      tests_run++;
      if (Pin_Out !== exp_pin) begin
        tests_failed++;
        $display("FAIL sat_pin c=%0d got=%b exp=%b", c, Pin_Out, exp_pin);
      end
      @(posedge CLOCK);
      #1;
    end
    Enable = 1'b1;
  endtask

  // Channels 0 and 2 refilled: strict alternation 001/100, channel 1 never.
  task automatic test_fairness();
    logic [2:0] exp_pin;
    do_reset();
    for (int c = 0; c < 41; c++) begin
      Event_In = (c == 0 || c == 1 || c == 10) ? 3'b101 : 3'b000;
      @(negedge CLOCK);
      case (c)
        2, 14, 26: exp_pin = 3'b001;
        8, 20, 32: exp_pin = 3'b100;
        default:   exp_pin = 3'b000;
      endcase
      tests_run++;
      if (Pin_Out !== exp_pin) begin
        tests_failed++;
        $display("FAIL rr_pin c=%0d got=%b exp=%b", c, Pin_Out, exp_pin);
      end
      @(posedge CLOCK);
      #1;
    end
  endtask

  // Clear during GAP with one event still queued; event in the Clear cycle is discarded.
  task automatic test_clear();
    logic [2:0] exp_pin;
    logic       exp_busy;
    do_reset();
    for (int c = 0; c < 21; c++) begin
      Event_In = (c <= 1) ? 3'b100 : (c == 4) ? 3'b001 : 3'b000;
      Clear    = (c == 4);
      @(negedge CLOCK);
      exp_pin  = (c == 2) ? 3'b100 : 3'b000;
      exp_busy = (c >= 2 && c <= 4);
      tests_run++;
      if (Pin_Out !== exp_pin) begin
        tests_failed++;
        $display("FAIL clear_pin c=%0d got=%b exp=%b", c, Pin_Out, exp_pin);
      end
      tests_run++;
      if (Busy !== exp_busy) begin
        tests_failed++;
        $display("FAIL clear_busy c=%0d got=%b exp=%b", c, Busy, exp_busy);
      end
      @(posedge CLOCK);
      #1;
    end
    Clear = 1'b0;
  endtask

  // Async reset while Pin_Out=100, then channel 0 wins first after release.
  task automatic test_async_reset();
    logic [2:0] exp_pin;
    do_reset();
    for (int c = 0; c < 3; c++) begin
      Event_In = (c == 0) ? 3'b100 : 3'b000;
      @(negedge CLOCK);
      if (c < 2) begin
        @(posedge CLOCK);
        #1;
      end
    end
    tests_run++;
    if (Pin_Out !== 3'b100) begin
      tests_failed++;
      $display("FAIL arst_pre_pin got=%b exp=100", Pin_Out);
    end
    #2;
    RST_n = 1'b0;
    #1;
    tests_run++;
    if (Pin_Out !== 3'b000) begin
      tests_failed++;
      $display("FAIL arst_pin got=%b exp=000", Pin_Out);
    end
    tests_run++;
    if (Busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL arst_busy got=%b exp=0", Busy);
    end
    @(posedge CLOCK);
    @(negedge CLOCK);
    RST_n = 1'b1;
    @(posedge CLOCK);
    #1;
    for (int c = 0; c < 12; c++) begin
      Event_In = (c == 0) ? 3'b011 : 3'b000;
      @(negedge CLOCK);
      case (c)
        2:       exp_pin = 3'b001;
        8:       exp_pin = 3'b010;
        default: exp_pin = 3'b000;
      endcase
      tests_run++;
      if (Pin_Out !== exp_pin) begin
        tests_failed++;
        $display("FAIL arst_after_pin c=%0d got=%b exp=%b", c, Pin_Out, exp_pin);
      end
      @(posedge CLOCK);
      #1;
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_saturation();
    test_fairness();
    test_clear();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/led_event_scheduler.md
Name: led_event_scheduler

Overview:
Sits between the key click detector (single, long and double click pulses) and the LED toggle block. It queues click events per channel and round-robins them onto the shared 3-bit one-hot toggle bus. It enforces a minimum gap between toggles so every toggle is visible on the LEDs, even when events arrive in bursts or simultaneously.

Parameters:
CNT_W, 2, width of each per-channel pending counter; max pending = 2^CNT_W-1 (3)
GAP_CYCLES, 25000000, idle cycles after each issued toggle (0.5 s at 50 MHz); legal range 1..2^GAP_W-1
GAP_W, 25, width of gap counter

Ports:
CLOCK  input  1  system clock, all logic on rising edge
RST_n  input  1  asynchronous active-low reset
Event_In  input  3  per-channel event strobes; each cycle high = one event; [2]=long, [1]=double, [0]=single click
Enable  input  1  1 = issuing allowed; 0 = hold issuing, keep queuing
Clear  input  1  synchronous flush of all pending events and FSM
Pin_Out  output  3  one-hot toggle strobe to LED block, high exactly one cycle per issue
Busy  output  1  high when FSM not IDLE
Drop_Flag  output  3  one-cycle pulse per channel when an event is lost to a saturated counter

Behaviour:
- Reset (RST_n=0, async): all pending counts = 0; FSM = IDLE; gap counter = 0; RR pointer last = 2; Pin_Out = 3'b000; Busy = 0; Drop_Flag = 3'b000. All outputs are registered.
- Pending counter i, per cycle:
  - Event_In[i] and no issue on i: increment.
  - Issue on i and no Event_In[i]: decrement.
  - Both in the same cycle: unchanged.
  - Increment while at max (3) and not issuing on i: count unchanged, Drop_Flag[i]=1 next cycle.
- FSM has three states: IDLE, ISSUE, GAP.
  - IDLE: if Enable=1 and any count>0, choose the first channel with count>0 scanning (last+1)%3, (last+2)%3, last. Register Pin_Out to that one-hot and update last. Go to ISSUE. Otherwise stay in IDLE.
  - ISSUE (exactly 1 cycle): Pin_Out asserted. Granted count decrements this cycle. Go to GAP with gap counter = 0.
  - GAP: gap counter increments each cycle. When it reaches GAP_CYCLES-1, go to IDLE. Pin_Out = 0 throughout.
- Latency: Event_In[i] high in cycle t, with FSM IDLE, Enable=1 and all counts previously 0, gives Pin_Out[i] high in cycle t+2.
- Minimum spacing between consecutive Pin_Out pulses is GAP_CYCLES+2 cycles.
- Enable=0: IDLE does not issue. ISSUE and GAP already in progress complete normally. Counts keep accumulating and saturating.
- Clear=1 (synchronous): next cycle all counts = 0, FSM = IDLE, gap counter = 0, Pin_Out = 0, Drop_Flag = 0. The last pointer is kept. Any Event_In in the Clear cycle is discarded. Clear has priority over every other action.
- Simultaneous events on multiple channels: all are counted in the same cycle. Issue order follows round-robin.
- Reset asserted mid-ISSUE or mid-GAP: outputs are forced to their reset values immediately (async). After release, operation starts from IDLE.
- Busy = (state != IDLE), registered alongside the state.

Test Plan:
- Single event, GAP_CYCLES=4: Event_In=3'b001 for 1 cycle at t -> Pin_Out=3'b001 only at t+2; Busy high t+2..t+6; IDLE at t+7.
- Simultaneous burst: Event_In=3'b111 for 1 cycle after reset -> Pin_Out sequence 001, 010, 100, each pulse 6 cycles apart (GAP_CYCLES=4); then counts = 0.
- Saturation: Enable=0, Event_In[1]=1 for 5 consecutive cycles -> count1=3; Drop_Flag[1] pulses twice. Enable=1 -> exactly 3 pulses of 3'b010.
- Round-robin fairness: keep counts 0 and 2 refilled continuously -> Pin_Out alternates 001, 100, 001, 100; channel 1 is never issued.
- Clear during GAP with count2=2 -> next cycle Busy=0 and all counts 0; no further Pin_Out pulses.
- Async reset mid-ISSUE: RST_n low while Pin_Out=3'b100 -> Pin_Out=000 and Busy=0 without waiting for a clock edge. After release, a fresh Event_In[0] is issued first (last=2).
